dshim_sized: RTL and testbench
==============================

// Module: dshim_sized
// PURPOSE
//  Parametrised data-memory shim between the Y86 memory stage and a byte-wide RAM.
//  Converts one sized access into a sequence of byte beats: byte, half, word, or dword (when WORD_W=64).
//  Supports configurable RAM read latency and optional sign extension on loads.
//  Rejects misaligned accesses with an error. Sits between the execute/memory pipeline stage and the RAM port.
// PARAMETERS
//  WORD_W   32  CPU data width; 32 or 64
//  ADDR_W   32  address width
//  RD_LAT    1  RAM read latency in cycles, >=1
// PORTS
//  clk            in   1        clock, rising edge
//  reset          in   1        asynchronous, active-low reset
//  req            in   1        access request; sampled only in IDLE
//  DMemWrite      in   1        1=store, 0=load; latched with req
//  size           in   2        00 byte, 01 half, 10 word, 11 dword; latched with req
//  sign_ext       in   1        1=sign-extend sub-word load; latched with req
//  addr           in   ADDR_W   byte address; latched with req
//  data_in        in   WORD_W   store data, LSBs used; latched with req
//  data_from_RAM  in   8        RAM read byte
//  RAMuse         out  1        shim owns the RAM port
//  RAMaddr        out  ADDR_W   RAM byte address
//  data_to_RAM    out  8        RAM write byte
//  RAMwrite       out  1        RAM write strobe, one cycle per beat
//  RAMread        out  1        RAM read strobe, one cycle per beat
//  busy           out  1        high in every state except IDLE
//  done           out  1        one-cycle completion pulse
//  err            out  1        high with done on a rejected access
//  data_out       out  WORD_W   load result; valid from done, held until the next load completes
// BEHAVIOUR
//  Reset (reset=0, asynchronous): FSM goes to IDLE. All outputs including data_out are 0. Any access in flight is abandoned; no done pulse.
//  FSM states: IDLE, WR, RD_ISS, RD_WAIT, RD_CAP, DONE, ERR.
//  IDLE, req=1:
//   - Latch all request inputs. Set N = 1<<size. Clear beat index i.
//   - Illegal if size=11 with WORD_W=32, or addr%N != 0 -> ERR.
//   - Otherwise -> WR if DMemWrite=1, else -> RD_ISS.
//  ERR: one cycle. done=1, err=1, no RAM strobes, data_out unchanged. Then -> IDLE.
//  WR: per cycle RAMuse=1, RAMwrite=1, RAMaddr=base+i, data_to_RAM=byte i of data (little-endian). After beat N-1 -> DONE.
//  Load beat sequence:
//   - RD_ISS: RAMuse=1, RAMread=1, RAMaddr=base+i.
//   - RD_WAIT: RD_LAT-1 cycles. RAMuse=1, RAMaddr held.
//   - RD_CAP: capture data_from_RAM into byte lane i. Then next beat, or DONE after beat N-1.
//  DONE: one cycle. done=1, err=0, RAMuse=0. Then -> IDLE.
//   - Load result: bytes >= N are zero-filled, or copies of bit 8N-1 if sign_ext=1. Dword ignores sign_ext.
//  Latency, req edge to done: store N+1 cycles; load N*(RD_LAT+1)+1 cycles; error 1 cycle.
//  req is ignored while busy. A req held high is re-accepted in IDLE, so the minimum gap between done pulses is 1 IDLE cycle.
//  Address wrap is impossible: aligned accesses never cross 2^ADDR_W. base+i is computed modulo 2^ADDR_W.
//  Outside WR, RAMwrite=0. Outside RD_ISS, RAMread=0. RAMread and RAMwrite are never both 1.
//  data_to_RAM is 0 when not in WR.
// STRUCTURE
//  Package/include dshim_defs.vh:
//   - size encodings SZ_BYTE..SZ_DWORD
//   - FSM state localparams
//   - function beats(size)
//  One sub-module, dshim_lane_pack: lane-indexed byte capture register plus sign/zero extension; combinational store byte select.
//  Top level holds the FSM, beat counter, and latency counter.
// TESTING (RAM model: byte array, configurable RD_LAT)
//  1. Word store 0xDEADBEEF @0x100, WORD_W=32 -> RAMwrite at cycles 1..4 to 0x100..0x103 with EF,BE,AD,DE; done at cycle 5; err=0.
//  2. Word load @0x100, RD_LAT=1 -> RAMread at cycles 1,3,5,7; done at cycle 9; data_out=0xDEADBEEF.
//  3. Loads after test 1:
//   - byte @0x103, sign_ext=1 -> 0xFFFFFFDE
//   - byte @0x103, sign_ext=0 -> 0x000000DE
//   - half @0x102, sign_ext=1 -> 0xFFFFDEAD
//  4. Misaligned accesses:
//   - word @0x101 -> done=err=1 at cycle 1, RAMuse never high, data_out unchanged
//   - size=11 with WORD_W=32 -> same response
//  5. reset=0 mid-store, during beat 2 -> RAMwrite/RAMuse drop immediately; 0x102/0x103 unchanged; no done. Next word load completes normally.
//  6. WORD_W=64, RD_LAT=3, dword load of 0x0123456789ABCDEF @0x200 -> done at cycle 33; data_out=0x0123456789ABCDEF.
//     req held high across done -> next access starts after 1 IDLE cycle.

Source files
------------

// File: rtl/dshim_sized_pkg.sv
// dshim_sized_pkg
// Shared definitions for the sized data-memory shim.
// Contents:
//   size_e   access size encodings (byte, half, word, dword)
//   state_e  shim FSM states
//   beats()  number of byte beats for an access size
package dshim_sized_pkg;

  // Access size as presented by the memory stage.
  typedef enum logic [1:0] {
    SZ_BYTE  = 2'b00,
    SZ_HALF  = 2'b01,
    SZ_WORD  = 2'b10,
    SZ_DWORD = 2'b11
  } size_e;

  // Shim FSM states.
  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_RD_ISS,
    S_RD_WAIT,
    S_RD_CAP,
    S_DONE,
    S_ERR
  } state_e;

  localparam int MAX_BEATS = 8;

  // Number of byte beats for an access of the given size.
  function automatic logic [3:0] beats(input size_e sz);
    return 4'd1 << sz;
  endfunction

endpackage

// File: rtl/dshim_sized_if.sv
// dshim_sized_if
// Bundles the memory-stage request/response signals and the byte-wide RAM
// port of the shim.
// Modports:
//   slave  : the shim (takes requests, drives RAM port and completion)
//   master : the memory stage / RAM side (drives requests and RAM read data)
// Signals:
//   req, DMemWrite, size, sign_ext, addr, data_in  request, latched on accept
//   data_from_RAM                                   RAM read byte
//   RAMuse, RAMaddr, data_to_RAM, RAMwrite, RAMread byte-wide RAM port
//   busy, done, err, data_out                       status and load result
interface dshim_sized_if #(
  parameter int WORD_W = 32,
  parameter int ADDR_W = 32
);
  logic              req;
  logic              DMemWrite;
  logic [1:0]        size;
  logic              sign_ext;
  logic [ADDR_W-1:0] addr;
  logic [WORD_W-1:0] data_in;
  logic [7:0]        data_from_RAM;
  logic              RAMuse;
  logic [ADDR_W-1:0] RAMaddr;
  logic [7:0]        data_to_RAM;
  logic              RAMwrite;
  logic              RAMread;
  logic              busy;
  logic              done;
  logic              err;
  logic [WORD_W-1:0] data_out;

  modport slave (
    input  req, DMemWrite, size, sign_ext, addr, data_in, data_from_RAM,
    output RAMuse, RAMaddr, data_to_RAM, RAMwrite, RAMread,
           busy, done, err, data_out
  );

  modport master (
    output req, DMemWrite, size, sign_ext, addr, data_in, data_from_RAM,
    input  RAMuse, RAMaddr, data_to_RAM, RAMwrite, RAMread,
           busy, done, err, data_out
  );
endinterface

// File: rtl/dshim_sized_lane_pack.sv
// dshim_lane_pack
// Byte-lane datapath of the shim.
// Ports:
//   clk, reset     clock and asynchronous active-low reset
//   capEn_i        capture capByte_i into lane capLane_i this cycle
//   capLane_i      lane index of the byte being captured
//   capByte_i      byte returned by the RAM
//   size_i         access size, selects how many lanes are kept
//   signExt_i      replicate the top kept bit into the upper lanes
//   stData_i       store word to pick a byte from
//   stLane_i       lane of stData_i to drive to the RAM
//   loadResult_o   extended load value, including a byte captured this cycle
//   stByte_o       selected store byte
module dshim_lane_pack
  import dshim_sized_pkg::*;
#(
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              capEn_i,
  input  logic [2:0]        capLane_i,
  input  logic [7:0]        capByte_i,
  input  size_e             size_i,
  input  logic              signExt_i,
  input  logic [WORD_W-1:0] stData_i,
  input  logic [2:0]        stLane_i,
  output logic [WORD_W-1:0] loadResult_o,
  output logic [7:0]        stByte_o
);
  localparam int NB = WORD_W / 8;

  logic [WORD_W-1:0] lanes_q;
  logic [WORD_W-1:0] lanes_d;
  logic              msb;
  logic [3:0]        keep;

  // The incoming byte is merged combinationally so the final beat is part
  // of loadResult_o in the same cycle it is captured.
  always_comb begin
    lanes_d = lanes_q;
    if (capEn_i) begin
      for (int j = 0; j < NB; j++) begin
        if (capLane_i == 3'(j)) lanes_d[8*j +: 8] = capByte_i;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) lanes_q <= '0;
    else        lanes_q <= lanes_d;
  end

  // Lanes beyond the access size are zero- or sign-filled; a dword fills
  // every lane so sign_ext has no effect there.
  always_comb begin
    keep = beats(size_i);
    msb  = 1'b0;
    unique case (size_i)
      SZ_BYTE: msb = lanes_d[7];
      SZ_HALF: msb = lanes_d[15];
      SZ_WORD: msb = lanes_d[31];
      default: msb = 1'b0;
    endcase
    loadResult_o = '0;
    for (int j = 0; j < NB; j++) begin
      if (4'(j) < keep)   loadResult_o[8*j +: 8] = lanes_d[8*j +: 8];
      else if (signExt_i) loadResult_o[8*j +: 8] = {8{msb}};
    end
  end

  // Little-endian store byte select.
  always_comb begin
    stByte_o = '0;
    for (int j = 0; j < NB; j++) begin
      if (stLane_i == 3'(j)) stByte_o = stData_i[8*j +: 8];
    end
  end

endmodule

// File: rtl/dshim_sized.sv
// dshim_sized
// Data-memory shim between the Y86 memory stage and a byte-wide RAM. One
// sized access becomes a sequence of byte beats; misaligned accesses are
// rejected with err.
// Parameters: WORD_W (32 or 64), ADDR_W, RD_LAT (RAM read latency, >=1)
// Ports:
//   clk    clock, rising edge
//   reset  asynchronous active-low reset
//   bus    dshim_sized_if.slave: request, RAM port, busy/done/err/data_out
module dshim_sized
  import dshim_sized_pkg::*;
#(
  parameter int WORD_W = 32,
  parameter int ADDR_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic         clk,
  input  logic         reset,
  dshim_sized_if.slave bus
);
  localparam int CNT_W = (RD_LAT > 2) ? $clog2(RD_LAT) : 1;

  state_e            state_q;
  logic [2:0]        idx_q;
  logic [CNT_W-1:0]  waitCnt_q;
  logic [ADDR_W-1:0] base_q;
  size_e             size_q;
  logic              signExt_q;
  logic [WORD_W-1:0] data_q;
  logic              RAMuse_q;
  logic [ADDR_W-1:0] RAMaddr_q;
  logic [7:0]        data_to_RAM_q;
  logic              RAMwrite_q;
  logic              RAMread_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;
  logic [WORD_W-1:0] data_out_q;

  size_e             reqSize;
  logic [3:0]        reqBeats;
  logic              reqIllegal;
  logic              lastBeat;
  logic [2:0]        idxNext;
  logic [WORD_W-1:0] stData;
  logic [2:0]        stLane;
  logic [7:0]        stByte;
  logic [WORD_W-1:0] loadResult;

  assign reqSize    = size_e'(bus.size);
  assign reqBeats   = beats(reqSize);
  assign reqIllegal = ((reqSize == SZ_DWORD) && (WORD_W == 32)) ||
                      (|(bus.addr[2:0] & 3'(reqBeats - 4'd1)));
  assign lastBeat   = ({1'b0, idx_q} == (beats(size_q) - 4'd1));
  assign idxNext    = idx_q + 3'd1;

  // Outputs are registered, so the store byte is chosen for the beat about
  // to start: byte 0 of the live request on accept, else the next lane.
  assign stData = (state_q == S_IDLE) ? bus.data_in : data_q;
  assign stLane = (state_q == S_IDLE) ? 3'd0 : idxNext;

  dshim_lane_pack #(.WORD_W(WORD_W)) u_lane_pack (
    .clk          (clk),
    .reset        (reset),
    .capEn_i      (state_q == S_RD_CAP),
    .capLane_i    (idx_q),
    .capByte_i    (bus.data_from_RAM),
    .size_i       (size_q),
    .signExt_i    (signExt_q),
    .stData_i     (stData),
    .stLane_i     (stLane),
    .loadResult_o (loadResult),
    .stByte_o     (stByte)
  );

  // FSM, beat counter and latency counter. Every output register is set on
  // the transition into the state it belongs to; strobes and pulses
  // default low each cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      idx_q         <= '0;
      waitCnt_q     <= '0;
      base_q        <= '0;
      size_q        <= SZ_BYTE;
      signExt_q     <= 1'b0;
      data_q        <= '0;
      RAMuse_q      <= 1'b0;
      RAMaddr_q     <= '0;
      data_to_RAM_q <= '0;
      RAMwrite_q    <= 1'b0;
      RAMread_q     <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      data_out_q    <= '0;
    end else begin
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      RAMwrite_q    <= 1'b0;
      RAMread_q     <= 1'b0;
      data_to_RAM_q <= '0;
      unique case (state_q)
        S_IDLE: begin
          if (bus.req) begin
            size_q    <= reqSize;
            signExt_q <= bus.sign_ext;
            data_q    <= bus.data_in;
            base_q    <= bus.addr;
            idx_q     <= '0;
            busy_q    <= 1'b1;
            if (reqIllegal) begin
              state_q <= S_ERR;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
            end else if (bus.DMemWrite) begin
              state_q       <= S_WR;
              RAMuse_q      <= 1'b1;
              RAMwrite_q    <= 1'b1;
              RAMaddr_q     <= bus.addr;
              data_to_RAM_q <= stByte;
            end else begin
              state_q   <= S_RD_ISS;
              RAMuse_q  <= 1'b1;
              RAMread_q <= 1'b1;
              RAMaddr_q <= bus.addr;
            end
          end
        end
        S_WR: begin
          if (lastBeat) begin
            state_q  <= S_DONE;
            RAMuse_q <= 1'b0;
            done_q   <= 1'b1;
          end else begin
            idx_q         <= idxNext;
            RAMaddr_q     <= base_q + ADDR_W'(idxNext);
            RAMwrite_q    <= 1'b1;
            data_to_RAM_q <= stByte;
          end
        end
        S_RD_ISS: begin
          if (RD_LAT > 1) begin
            state_q   <= S_RD_WAIT;
            waitCnt_q <= CNT_W'(RD_LAT - 2);
          end else begin
            state_q <= S_RD_CAP;
          end
        end
        S_RD_WAIT: begin
          if (waitCnt_q == '0) state_q <= S_RD_CAP;
          else                 waitCnt_q <= waitCnt_q - CNT_W'(1);
        end
        S_RD_CAP: begin
          if (lastBeat) begin
            state_q    <= S_DONE;
            RAMuse_q   <= 1'b0;
            done_q     <= 1'b1;
            data_out_q <= loadResult;
          end else begin
            state_q   <= S_RD_ISS;
            idx_q     <= idxNext;
            RAMread_q <= 1'b1;
            RAMaddr_q <= base_q + ADDR_W'(idxNext);
          end
        end
        S_DONE, S_ERR: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q  <= S_IDLE;
          busy_q   <= 1'b0;
          RAMuse_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.RAMuse      = RAMuse_q;
  assign bus.RAMaddr     = RAMaddr_q;
  assign bus.data_to_RAM = data_to_RAM_q;
  assign bus.RAMwrite    = RAMwrite_q;
  assign bus.RAMread     = RAMread_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.err         = err_q;
  assign bus.data_out    = data_out_q;

endmodule

// File: tb/tb_dshim_sized.sv
// tb_dshim_sized
// Drives two shims (WORD_W=32/RD_LAT=1 and WORD_W=64/RD_LAT=3), each with a
// byte-array RAM model. Expected responses are queued at issue time and
// popped by per-DUT monitors on each done pulse.
module tb_dshim_sized;

  typedef struct {
    logic        err;
    logic [63:0] data;
    int          cyc;
  } exp_t;

  typedef struct {
    int          cyc;
    logic        wr;
    logic [31:0] a;
    logic [7:0]  d;
  } acc_t;

  logic clk = 1'b0;
  logic reset;
  int   cycleCnt = 0;
  int   checks = 0;
  int   failures = 0;

  exp_t q32[$];
  exp_t q64[$];
  acc_t log32[$];
  exp_t e32;
  exp_t e64;

  logic [7:0] ram32 [0:1023];
  logic [7:0] ram64 [0:1023];
  logic [7:0] pipe32;
  logic [7:0] pipe64 [0:2];

  logic [63:0] last32 = '0;
  logic [63:0] last64 = '0;
  logic        useSeen = 1'b0;
  logic        strobeClash = 1'b0;

  dshim_sized_if #(.WORD_W(32), .ADDR_W(32)) bus32 ();
  dshim_sized_if #(.WORD_W(64), .ADDR_W(32)) bus64 ();

  dshim_sized #(.WORD_W(32), .ADDR_W(32), .RD_LAT(1)) dut32 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus32)
  );

  dshim_sized #(.WORD_W(64), .ADDR_W(32), .RD_LAT(3)) dut64 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus64)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  // RAM models: writes land on the clock edge, reads return after RD_LAT edges.
  always @(posedge clk) begin
    if (bus32.RAMwrite) ram32[bus32.RAMaddr[9:0]] <= bus32.data_to_RAM;
    pipe32 <= bus32.RAMread ? ram32[bus32.RAMaddr[9:0]] : 8'h00;
    pipe64[0] <= bus64.RAMread ? ram64[bus64.RAMaddr[9:0]] : 8'h00;
    pipe64[1] <= pipe64[0];
    pipe64[2] <= pipe64[1];
  end

  assign bus32.data_from_RAM = pipe32;
  assign bus64.data_from_RAM = pipe64[2];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Bus activity log for the 32-bit shim, plus sticky strobe observations.
  always @(negedge clk) begin
    if (bus32.RAMwrite || bus32.RAMread)
      log32.push_back('{cycleCnt, bus32.RAMwrite, bus32.RAMaddr, bus32.data_to_RAM});
    if (bus32.RAMuse) useSeen = 1'b1;
    if ((bus32.RAMread && bus32.RAMwrite) || (bus64.RAMread && bus64.RAMwrite))
      strobeClash = 1'b1;
  end

  // Monitor for the 32-bit shim.
  always @(negedge clk) begin
    if (bus32.done) begin
      if (q32.size() == 0) begin
        checkOutput("spurious_done32", 64'd1, 64'd0);
      end else begin
        e32 = q32.pop_front();
        checkOutput("err32", 64'(bus32.err), 64'(e32.err));
        checkOutput("data32", 64'(bus32.data_out), e32.data);
        checkOutput("donecyc32", 64'(cycleCnt), 64'(e32.cyc));
      end
    end
  end

  // Monitor for the 64-bit shim.
  always @(negedge clk) begin
    if (bus64.done) begin
      if (q64.size() == 0) begin
        checkOutput("spurious_done64", 64'd1, 64'd0);
      end else begin
        e64 = q64.pop_front();
        checkOutput("err64", 64'(bus64.err), 64'(e64.err));
        checkOutput("data64", bus64.data_out, e64.data);
        checkOutput("donecyc64", 64'(cycleCnt), 64'(e64.cyc));
      end
    end
  end

  // Wait, with a cycle bound, until the monitor has consumed every response.
  task automatic waitDrain(input bit is64);
    int n = 0;
    while (((is64 ? q64.size() : q32.size()) != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if ((is64 ? q64.size() : q32.size()) != 0) begin
      checkOutput(is64 ? "drain_timeout64" : "drain_timeout32", 64'd1, 64'd0);
      if (is64) q64.delete();
      else      q32.delete();
    end
  endtask

  // Issue one access for one cycle, queue its expected response, then drain.
  // Stores and errors expect data_out to keep its previous value.
  task automatic applyStimulus(input bit is64, input logic wr, input logic [1:0] sz,
                               input logic se, input logic [31:0] a, input logic [63:0] d,
                               input logic expErr, input logic [63:0] expData,
                               input int lat, output int startCyc);
    exp_t e;
    @(posedge clk); #1;
    if (is64) begin
      bus64.DMemWrite = wr; bus64.size = sz; bus64.sign_ext = se;
      bus64.addr = a; bus64.data_in = d; bus64.req = 1'b1;
      if (!wr && !expErr) last64 = expData;
      e.data = last64;
    end else begin
      bus32.DMemWrite = wr; bus32.size = sz; bus32.sign_ext = se;
      bus32.addr = a; bus32.data_in = d[31:0]; bus32.req = 1'b1;
      if (!wr && !expErr) last32 = expData;
      e.data = last32;
    end
    e.err = expErr;
    e.cyc = cycleCnt + lat;
    startCyc = cycleCnt;
    if (is64) q64.push_back(e);
    else      q32.push_back(e);
    @(posedge clk); #1;
    bus32.req = 1'b0;
    bus64.req = 1'b0;
    waitDrain(is64);
  endtask

  task automatic checkLog(input int idx, input int expCyc, input logic expWr,
                          input logic [31:0] expA, input logic [7:0] expD);
    if (idx >= log32.size()) begin
      checkOutput("log_missing", 64'(idx), 64'(log32.size()));
    end else begin
      checkOutput("log_cycle", 64'(log32[idx].cyc), 64'(expCyc));
      checkOutput("log_kind", 64'(log32[idx].wr), 64'(expWr));
      checkOutput("log_addr", 64'(log32[idx].a), 64'(expA));
      checkOutput("log_byte", 64'(log32[idx].d), 64'(expD));
    end
  endtask

  // Global time bound.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int st;
    logic [31:0] w;
    logic [63:0] pat;
    reset = 1'b0;
    bus32.req = 0; bus32.DMemWrite = 0; bus32.size = 0; bus32.sign_ext = 0;
    bus32.addr = 0; bus32.data_in = 0;
    bus64.req = 0; bus64.DMemWrite = 0; bus64.size = 0; bus64.sign_ext = 0;
    bus64.addr = 0; bus64.data_in = 0;
    pat = 64'h0123456789ABCDEF;
    for (int j = 0; j < 8; j++) ram64[10'h200 + 10'(j)] = pat[8*j +: 8];

    // Reset state.
    repeat (2) @(posedge clk); #1;
    checkOutput("rst_data_out32", 64'(bus32.data_out), 64'd0);
    checkOutput("rst_busy32", 64'(bus32.busy), 64'd0);
    checkOutput("rst_done32", 64'(bus32.done), 64'd0);
    checkOutput("rst_ramuse32", 64'(bus32.RAMuse), 64'd0);
    checkOutput("rst_data_out64", bus64.data_out, 64'd0);
    reset = 1'b1;

    // Word store: four write beats in cycles 1..4, done at 5.
    log32.delete();
    applyStimulus(0, 1, 2'b10, 0, 32'h100, 64'hDEADBEEF, 0, 64'h0, 5, st);
    checkOutput("t1_nbeats", 64'(log32.size()), 64'd4);
    w = 32'hDEADBEEF;
    for (int j = 0; j < 4; j++) checkLog(j, st + 1 + j, 1'b1, 32'h100 + 32'(j), w[8*j +: 8]);

    // Word load: read strobes in cycles 1,3,5,7, done at 9.
    log32.delete();
    applyStimulus(0, 0, 2'b10, 0, 32'h100, 64'h0, 0, 64'hDEADBEEF, 9, st);
    checkOutput("t2_nbeats", 64'(log32.size()), 64'd4);
    for (int j = 0; j < 4; j++) checkLog(j, st + 1 + 2*j, 1'b0, 32'h100 + 32'(j), 8'h00);

    // Sub-word loads with and without sign extension.
    applyStimulus(0, 0, 2'b00, 1, 32'h103, 64'h0, 0, 64'hFFFFFFDE, 3, st);
    applyStimulus(0, 0, 2'b00, 0, 32'h103, 64'h0, 0, 64'h000000DE, 3, st);
    applyStimulus(0, 0, 2'b01, 1, 32'h102, 64'h0, 0, 64'hFFFFDEAD, 5, st);

    // Rejected accesses: misaligned word and dword on a 32-bit shim.
    useSeen = 1'b0;
    applyStimulus(0, 0, 2'b10, 0, 32'h101, 64'h0, 1, 64'h0, 1, st);
    applyStimulus(0, 0, 2'b11, 0, 32'h100, 64'h0, 1, 64'h0, 1, st);
    checkOutput("t4_ramuse_seen", 64'(useSeen), 64'd0);

    // Reset during beat 2 of a store: no done, upper bytes untouched.
    @(posedge clk); #1;
    bus32.DMemWrite = 1; bus32.size = 2'b10; bus32.sign_ext = 0;
    bus32.addr = 32'h100; bus32.data_in = 32'h11223344; bus32.req = 1'b1;
    @(posedge clk); #1;
    bus32.req = 1'b0;
    @(posedge clk);
    @(posedge clk); #2;
    checkOutput("t5_beat2_addr", 64'(bus32.RAMaddr), 64'h102);
    reset = 1'b0;
    #1;
    checkOutput("t5_ramwrite", 64'(bus32.RAMwrite), 64'd0);
    checkOutput("t5_ramuse", 64'(bus32.RAMuse), 64'd0);
    checkOutput("t5_data_out", 64'(bus32.data_out), 64'd0);
    last32 = '0;
    last64 = '0;
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    checkOutput("t5_ram100", 64'(ram32[10'h100]), 64'h44);
    checkOutput("t5_ram101", 64'(ram32[10'h101]), 64'h33);
    checkOutput("t5_ram102", 64'(ram32[10'h102]), 64'hAD);
    checkOutput("t5_ram103", 64'(ram32[10'h103]), 64'hDE);
    applyStimulus(0, 0, 2'b10, 0, 32'h100, 64'h0, 0, 64'hDEAD3344, 9, st);

    // Dword load on the 64-bit shim with req held across done.
    @(posedge clk); #1;
    bus64.DMemWrite = 0; bus64.size = 2'b11; bus64.sign_ext = 1;
    bus64.addr = 32'h200; bus64.data_in = 64'h0; bus64.req = 1'b1;
    st = cycleCnt;
    last64 = 64'h0123456789ABCDEF;
    q64.push_back('{1'b0, 64'h0123456789ABCDEF, st + 33});
    q64.push_back('{1'b0, 64'h0123456789ABCDEF, st + 67});
    repeat (35) @(posedge clk);
    #1;
    bus64.req = 1'b0;
    waitDrain(1);

    // 64-bit sub-word extension and a misaligned dword.
    applyStimulus(1, 0, 2'b00, 1, 32'h201, 64'h0, 0, 64'hFFFFFFFFFFFFFFCD, 5, st);
    applyStimulus(1, 0, 2'b10, 1, 32'h204, 64'h0, 0, 64'h0000000001234567, 17, st);
    applyStimulus(1, 0, 2'b10, 1, 32'h200, 64'h0, 0, 64'hFFFFFFFF89ABCDEF, 17, st);
    applyStimulus(1, 0, 2'b11, 0, 32'h204, 64'h0, 1, 64'h0, 1, st);

    repeat (3) @(posedge clk);
    checkOutput("strobe_exclusive", 64'(strobeClash), 64'd0);
    checkOutput("leftover32", 64'(q32.size()), 64'd0);
    checkOutput("leftover64", 64'(q64.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
